// File: rtl/chk_fail_logger.sv
// chk_fail_logger: per-checker saturating fail counters plus timestamped failure
// records, one pending slot per checker, drained through a first-word-fall-through FIFO.
module chk_fail_logger #(
    parameter int NUM_CHK = 4,
    parameter int CNT_W   = 8,
    parameter int TS_W    = 16,
    parameter int DEPTH   = 8,
    parameter int ID_W    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       clear,
    input  logic [NUM_CHK-1:0]         fail_i,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [ID_W-1:0]            rec_id,
    output logic [TS_W-1:0]            rec_ts,
    output logic [NUM_CHK*CNT_W-1:0]   fail_cnt,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    logic [TS_W-1:0]      ts;
    logic [NUM_CHK-1:0]   pending;
    logic [TS_W-1:0]      ts_hold [NUM_CHK];
    logic [ID_W+TS_W-1:0] mem [DEPTH];
    logic [AW:0]          wptr, rptr;
    logic [ID_W-1:0]      sel;
    logic [TS_W-1:0]      sel_ts;
    logic [NUM_CHK-1:0]   pushed, hit;
    logic                 empty, full, pop, push;
    // lowest-index pending checker wins the single push slot
    always_comb begin
        sel = '0;
        sel_ts = '0;
        for (int k = NUM_CHK - 1; k >= 0; k--)
            if (pending[k]) begin
                sel = ID_W'(k);
                sel_ts = ts_hold[k];
            end
    end
    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = !empty && rec_ready;
    assign push  = |pending && (!full || pop);
    assign hit   = enable ? fail_i : '0;
    always_comb begin
        pushed = '0;
        for (int k = 0; k < NUM_CHK; k++)
            pushed[k] = push && (sel == ID_W'(k));
    end
    assign rec_valid         = !empty;
    assign {rec_id, rec_ts}  = empty ? '0 : mem[rptr[AW-1:0]];
    assign level             = wptr - rptr;
    always_ff @(posedge clk)
        if (push)
            mem[wptr[AW-1:0]] <= {sel, sel_ts};
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ts       <= '0;
            pending  <= '0;
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            fail_cnt <= '0;
            for (int k = 0; k < NUM_CHK; k++)
                ts_hold[k] <= '0;
        end else begin
            if (enable)
                ts <= ts + 1'b1;
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            // a repeat fail on a slot that is not draining this cycle is lost
            for (int k = 0; k < NUM_CHK; k++)
                if (hit[k]) begin
                    if (~&fail_cnt[k*CNT_W +: CNT_W])
                        fail_cnt[k*CNT_W +: CNT_W] <= fail_cnt[k*CNT_W +: CNT_W] + 1'b1;
                    if (pending[k] && !pushed[k])
                        overflow <= 1'b1;
                    else
                        ts_hold[k] <= ts;
                end
            pending <= (pending & ~pushed) | hit;
        end
    end
endmodule
